// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the buffered 1-to-16 demultiplexer.
package demux_pkg;

  localparam int NUM_OUT = 16;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } buf_state_t;

endpackage

// File: rtl/demux16_1_buf_decoder4_16.sv
// Combinational 4-to-16 one-hot decoder; all outputs low when disabled.
module decoder4_16
  import demux_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) begin
      dec[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux16_1_buf.sv
// Registered 1-to-16 demultiplexer with a two-entry skid buffer and
// valid/ready handshakes on both sides; words leave in acceptance order.
module demux16_1_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data
);

  buf_state_t       state_q, state_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             out_fire;

  // in_ready decodes only the state register so upstream sees no comb path.
  assign in_ready = (state_q != FULL) & ~reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = (state_q != EMPTY) & out_ready[out_sel_q];
  assign out_data = out_data_q;

  always_comb begin
    state_d     = state_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    skid_sel_d  = skid_sel_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_sel_d  = in_sel;
          out_data_d = in_data;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          out_sel_d  = in_sel;
          out_data_d = in_data;
        end else if (in_fire) begin
          skid_sel_d  = in_sel;
          skid_data_d = in_data;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_sel_d  = skid_sel_q;
          out_data_d = skid_data_q;
          state_d    = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      out_sel_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
    end
  end

  // Skid contents are only meaningful in FULL, so they need no reset.
  always_ff @(posedge clk) begin
    skid_sel_q  <= skid_sel_d;
    skid_data_q <= skid_data_d;
  end

  decoder4_16 u_decoder (
    .en  (state_q != EMPTY),
    .sel (out_sel_q),
    .dec (out_valid)
  );

endmodule
